// File: rtl/srl_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fifo_ctrl_pkg
//  Description : Occupancy-update encoding for the shift-register FIFO control.
//  Revision    : 1.0 - initial release
// ============================================================================
package srl_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2,
        LVL_CLR  = 2'd3
    } lvl_op_e;

endpackage : srl_fifo_ctrl_pkg
`default_nettype wire

// File: rtl/srl_fifo_store.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fifo_store
//  Description : Reset-free shift-register store with an addressed read tap.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_fifo_store #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 130,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    // No reset here: a reset on these bits would block SRL mapping.
    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    // Addresses past the last entry are unreachable; fold them onto sr[0].
    always_comb begin
        q = sr[0];
        if ({1'b0, addr} < (AW+1)'(DEPTH)) begin
            q = sr[addr];
        end
    end

endmodule : srl_fifo_store
`default_nettype wire

// File: rtl/srl_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fifo_ctrl
//  Description : Shift-register FIFO: occupancy counter, flags and handshake
//                around a single reset-free data store.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_fifo_ctrl
    import srl_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 130
) (
    input  logic                       clk,
    input  logic                       rn,
    input  logic                       flush,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [WIDTH-1:0]           i,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int C_CW = $clog2(DEPTH + 1);
    localparam int C_AW = $clog2(DEPTH);

    logic [C_CW-1:0] level_q;
    logic [C_CW-1:0] level_d;
    logic [C_CW-1:0] w_level_m1;
    logic [C_AW-1:0] w_addr;
    logic            w_push;
    logic            w_pop;
    lvl_op_e         w_op;

    assign i_ready    = (level_q != C_CW'(DEPTH));
    assign o_valid    = (level_q != '0);
    assign w_push     = i_valid & i_ready;
    assign w_pop      = o_valid & o_ready;
    assign level      = level_q;
    assign w_level_m1 = level_q - C_CW'(1);
    assign w_addr     = o_valid ? w_level_m1[C_AW-1:0] : '0;

    // Flush dominates; a simultaneous push still shifts the store but is not counted.
    always_comb begin
        w_op = LVL_HOLD;
        if (flush) begin
            w_op = LVL_CLR;
        end else if (w_push && !w_pop) begin
            w_op = LVL_INC;
        end else if (w_pop && !w_push) begin
            w_op = LVL_DEC;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case (w_op)
            LVL_CLR:  level_d = '0;
            LVL_INC:  level_d = level_q + C_CW'(1);
            LVL_DEC:  level_d = level_q - C_CW'(1);
            default:  level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    srl_fifo_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (C_AW)
    ) u_store (
        .clk  (clk),
        .en   (w_push),
        .d    (i),
        .addr (w_addr),
        .q    (q)
    );

endmodule : srl_fifo_ctrl
`default_nettype wire

// File: tb/tb_srl_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srl_fifo_ctrl
//  Description : Self-checking bench for srl_fifo_ctrl (WIDTH=8, DEPTH=130).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_fifo_ctrl;

    localparam int C_W = 8;
    localparam int C_D = 130;

    logic           clk = 1'b0;
    logic           rn = 1'b0;
    logic           flush = 1'b0;
    logic           i_valid = 1'b0;
    logic           o_ready = 1'b0;
    logic [C_W-1:0] din = '0;
    logic           i_ready;
    logic           o_valid;
    logic [C_W-1:0] q;
    logic [7:0]     level;

    int errors = 0;
    int checks = 0;
    logic [C_W-1:0] mq[$];

    typedef struct {
        logic           f;
        logic           iv;
        logic [C_W-1:0] d;
        logic           ordy;
        int             exp_lvl;
    } vec_t;

    vec_t tbl[8];

    srl_fifo_ctrl #(.WIDTH(C_W), .DEPTH(C_D)) dut (
        .clk     (clk),
        .rn      (rn),
        .flush   (flush),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i       (din),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .q       (q),
        .level   (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check flags/pop data at negedge, update model, check level.
    task automatic step(input logic f, input logic iv, input logic [C_W-1:0] d, input logic ordy);
        logic mpush;
        logic mpop;
        flush   = f;
        i_valid = iv;
        din     = d;
        o_ready = ordy;
        @(negedge clk);
        chk("o_valid", {31'd0, o_valid}, {31'd0, mq.size() != 0});
        chk("i_ready", {31'd0, i_ready}, {31'd0, mq.size() != C_D});
        mpush = iv && (mq.size() != C_D);
        mpop  = ordy && (mq.size() != 0);
        if (mpop) chk("q_pop", {24'd0, q}, {24'd0, mq[0]});
        @(posedge clk);
        #1;
        if (mpop) void'(mq.pop_front());
        if (mpush) mq.push_back(d);
        if (f) mq.delete();
        chk("level", {24'd0, level}, mq.size());
    endtask

    initial begin
        tbl[0] = '{f:1'b0, iv:1'b1, d:8'h11, ordy:1'b0, exp_lvl:1};
        tbl[1] = '{f:1'b0, iv:1'b1, d:8'h22, ordy:1'b1, exp_lvl:1};
        tbl[2] = '{f:1'b0, iv:1'b0, d:8'h00, ordy:1'b1, exp_lvl:0};
        tbl[3] = '{f:1'b0, iv:1'b0, d:8'h00, ordy:1'b1, exp_lvl:0};
        tbl[4] = '{f:1'b0, iv:1'b1, d:8'h33, ordy:1'b1, exp_lvl:1};
        tbl[5] = '{f:1'b1, iv:1'b0, d:8'h00, ordy:1'b0, exp_lvl:0};
        tbl[6] = '{f:1'b0, iv:1'b1, d:8'h44, ordy:1'b0, exp_lvl:1};
        tbl[7] = '{f:1'b1, iv:1'b1, d:8'h55, ordy:1'b0, exp_lvl:0};

        #12 rn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_level", {24'd0, level}, 32'd0);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_i_ready", {31'd0, i_ready}, 32'd1);

        for (int k = 0; k < 8; k++) begin
            step(tbl[k].f, tbl[k].iv, tbl[k].d, tbl[k].ordy);
            chk("tbl_level", {24'd0, level}, tbl[k].exp_lvl);
        end

        // Fill to full, then one ignored push.
        for (int k = 1; k <= C_D; k++) step(1'b0, 1'b1, C_W'(k), 1'b0);
        chk("full_level", {24'd0, level}, 32'd130);
        chk("full_i_ready", {31'd0, i_ready}, 32'd0);
        chk("full_q", {24'd0, q}, 32'h01);
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        chk("full_ignore", {24'd0, level}, 32'd130);

        // Drain completely.
        for (int k = 0; k < C_D; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drain_level", {24'd0, level}, 32'd0);
        chk("drain_o_valid", {31'd0, o_valid}, 32'd0);

        // Steady push+pop at level 5.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, C_W'(8'hA0 + k), 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, C_W'(8'hB0 + k), 1'b1);
            chk("pp_level", {24'd0, level}, 32'd5);
        end

        // Flush with a coincident push at level 40.
        for (int k = 0; k < 35; k++) step(1'b0, 1'b1, C_W'(8'hC0 + k), 1'b0);
        chk("lvl40", {24'd0, level}, 32'd40);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("flush_level", {24'd0, level}, 32'd0);
        chk("flush_o_valid", {31'd0, o_valid}, 32'd0);
        chk("flush_i_ready", {31'd0, i_ready}, 32'd1);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        chk("flush_next_q", {24'd0, q}, 32'h77);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-cycle at level 77.
        for (int k = 0; k < 77; k++) step(1'b0, 1'b1, C_W'(k * 3), 1'b0);
        chk("lvl77", {24'd0, level}, 32'd77);
        i_valid = 1'b0;
        #2 rn = 1'b0;
        #1;
        chk("arst_level", {24'd0, level}, 32'd0);
        chk("arst_o_valid", {31'd0, o_valid}, 32'd0);
        mq.delete();
        #1 rn = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        chk("arst_q", {24'd0, q}, 32'h5A);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 40) == 0, 1'($urandom), C_W'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_srl_fifo_ctrl
`default_nettype wire
